// File: rtl/msft_intc_pkg.sv
// Shared constants for the APB interrupt controller: register offsets,
// size limits and CLAIM word layout.
package msft_intc_pkg;

  localparam int NUM_IRQ_MAX = 32;
  localparam int NUM_TGT_MAX = 8;

  typedef logic [5:0] word_idx_t;

  localparam logic [7:0] OFF_PENDING = 8'h00;
  localparam logic [7:0] OFF_MODE    = 8'h04;
  localparam logic [7:0] OFF_RAW     = 8'h08;
  localparam logic [7:0] OFF_TIMER   = 8'h0C;
  localparam logic [7:0] OFF_ENABLE  = 8'h20;
  localparam logic [7:0] OFF_CLAIM   = 8'h40;

  // Only paddr[7:2] is decoded, so the datapath compares word indices.
  localparam word_idx_t W_PENDING = OFF_PENDING[7:2];
  localparam word_idx_t W_MODE    = OFF_MODE[7:2];
  localparam word_idx_t W_RAW     = OFF_RAW[7:2];
  localparam word_idx_t W_TIMER   = OFF_TIMER[7:2];
  localparam word_idx_t W_ENABLE  = OFF_ENABLE[7:2];
  localparam word_idx_t W_CLAIM   = OFF_CLAIM[7:2];

  localparam int CLAIM_VALID_BIT = 31;
  localparam int CLAIM_ID_W      = 5;

  function automatic logic [31:0] claim_word(input logic valid,
                                             input logic [CLAIM_ID_W-1:0] id);
    logic [31:0] w;
    w = '0;
    w[CLAIM_VALID_BIT]  = valid;
    w[CLAIM_ID_W-1:0]   = id;
    return w;
  endfunction

endpackage

// File: rtl/msft_intc_prio_enc.sv
// Lowest-index priority encoder: returns valid plus the id of the lowest set
// bit of the input vector.
module msft_intc_prio_enc
  import msft_intc_pkg::*;
#(
  parameter int NUM_IRQ = 32
) (
  input  logic [NUM_IRQ-1:0]    vec,
  output logic                  valid,
  output logic [CLAIM_ID_W-1:0] id
);

  // NOTE: every output gets a default before the loop, otherwise a
  // combinational block that assigns only on some paths infers a latch.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    // Scan high to low so the last hit, the lowest index, wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        id    = CLAIM_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/msft_apb_intc_gen2.sv
// APB interrupt controller with per-source edge/level mode, per-target enable
// and claim, plus a 32-bit system timer. MSFT_INTC_SYNC_EN adds a 2-flop input synchroniser.
module msft_apb_intc_gen2
  import msft_intc_pkg::*;
#(
  parameter int NUM_IRQ = 32,
  parameter int NUM_TGT = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic [31:0]        paddr_i,
  input  logic [31:0]        pwdata_i,
  input  logic               pwrite_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic [NUM_IRQ-1:0] irqs_i,
  output logic [NUM_TGT-1:0] irq_o
);

  logic [NUM_IRQ-1:0]    src, raw_q, prev_q, mode_q, edge_pend_q, pending;
  logic [NUM_IRQ-1:0]    w1c_clr, claim_clr;
  logic [NUM_IRQ-1:0]    enable_q [NUM_TGT];
  logic [NUM_IRQ-1:0]    masked   [NUM_TGT];
  logic [NUM_TGT-1:0]    claim_valid;
  logic [CLAIM_ID_W-1:0] claim_id [NUM_TGT];
  logic [31:0]           timer_q, rdata;
  word_idx_t             word;
  logic                  wr_en, rd_setup;
  logic                  unused_addr;

  assign word        = paddr_i[7:2];
  assign wr_en       = psel_i & penable_i & pwrite_i;
  assign rd_setup    = psel_i & ~penable_i & ~pwrite_i;
  assign pready_o    = 1'b1;
  assign pslverr_o   = 1'b0;
  assign unused_addr = ^{paddr_i[31:8], paddr_i[1:0]};

`ifdef MSFT_INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irqs_i;
      sync2_q <= sync1_q;
    end
  end
  assign src = sync2_q;
`else
  assign src = irqs_i;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (prev_q sees the old raw_q).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      raw_q  <= '0;
      prev_q <= '0;
    end else begin
      raw_q  <= src;
      prev_q <= raw_q;
    end
  end

  always_comb begin
    w1c_clr   = '0;
    claim_clr = '0;
    if (wr_en && word == W_PENDING) w1c_clr = pwdata_i[NUM_IRQ-1:0];
    for (int t = 0; t < NUM_TGT; t++) begin
      if (wr_en && word == W_CLAIM + word_idx_t'(t)) begin
        // Matching against each valid index drops ids >= NUM_IRQ for free.
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (pwdata_i[CLAIM_ID_W-1:0] == CLAIM_ID_W'(i)) claim_clr[i] = 1'b1;
        end
      end
    end
  end

  // Edge pending is held at 0 while a source is in level mode, so a
  // level->edge switch starts clean. A new rising edge beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) edge_pend_q <= '0;
    else         edge_pend_q <= mode_q & ((edge_pend_q & ~(w1c_clr | claim_clr))
                                          | (raw_q & ~prev_q));
  end

  assign pending = (mode_q & edge_pend_q) | (~mode_q & raw_q);

  // NOTE: the enable array is a handful of flops, not a RAM, so it is reset
  // along with the rest of the register file.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q  <= '0;
      timer_q <= '0;
      for (int t = 0; t < NUM_TGT; t++) enable_q[t] <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
      if (wr_en) begin
        if (word == W_MODE)  mode_q  <= pwdata_i[NUM_IRQ-1:0];
        if (word == W_TIMER) timer_q <= pwdata_i;
        for (int t = 0; t < NUM_TGT; t++) begin
          if (word == W_ENABLE + word_idx_t'(t)) enable_q[t] <= pwdata_i[NUM_IRQ-1:0];
        end
      end
    end
  end

  for (genvar t = 0; t < NUM_TGT; t++) begin : g_tgt
    assign masked[t] = pending & enable_q[t];
    assign irq_o[t]  = |masked[t];

    msft_intc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
      .vec   (masked[t]),
      .valid (claim_valid[t]),
      .id    (claim_id[t])
    );
  end

  always_comb begin
    rdata = '0;
    case (word)
      W_PENDING: rdata = 32'(pending);
      W_MODE:    rdata = 32'(mode_q);
      W_RAW:     rdata = 32'(raw_q);
      W_TIMER:   rdata = timer_q;
      default: begin
        for (int t = 0; t < NUM_TGT; t++) begin
          if (word == W_ENABLE + word_idx_t'(t)) rdata = 32'(enable_q[t]);
          if (word == W_CLAIM + word_idx_t'(t))  rdata = claim_word(claim_valid[t], claim_id[t]);
        end
      end
    endcase
  end

  // Read data is captured in the setup phase and is zero on all other cycles.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) prdata_o <= '0;
    else         prdata_o <= rd_setup ? rdata : '0;
  end

endmodule

// File: tb/tb_msft_apb_intc_gen2.sv
// Self-checking bench for msft_apb_intc_gen2: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_msft_apb_intc_gen2;

  localparam int NUM_IRQ = 32;
  localparam int NUM_TGT = 4;

  logic               clk_i = 1'b0;
  logic               rstn_i = 1'b0;
  logic               psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0]        paddr_i = '0, pwdata_i = '0;
  logic [31:0]        prdata_o;
  logic               pready_o, pslverr_o;
  logic [NUM_IRQ-1:0] irqs_i = '0;
  logic [NUM_TGT-1:0] irq_o;

  msft_apb_intc_gen2 #(.NUM_IRQ(NUM_IRQ), .NUM_TGT(NUM_TGT)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .pwrite_i  (pwrite_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .irqs_i    (irqs_i),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cyc;

  // Reference model: mode, latched edge events, current source levels, enables.
  logic [31:0] m_mode, m_edge, m_lvl;
  logic [31:0] m_en [NUM_TGT];
  logic [31:0] m_tbase;
  int          m_tcyc;

  function automatic logic [31:0] m_pending();
    return (m_edge & m_mode) | (m_lvl & ~m_mode);
  endfunction

  function automatic logic [31:0] m_claim(input int t);
    logic [31:0] v;
    v = m_pending() & m_en[t];
    for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return 32'h8000_0000 | 32'(i);
    return 32'h0;
  endfunction

  function automatic logic [NUM_TGT-1:0] m_irq();
    logic [NUM_TGT-1:0] r;
    for (int t = 0; t < NUM_TGT; t++) r[t] = |(m_pending() & m_en[t]);
    return r;
  endfunction

  task automatic model_clear();
    m_mode = '0; m_edge = '0; m_lvl = 32'(irqs_i);
    for (int t = 0; t < NUM_TGT; t++) m_en[t] = '0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
    @(negedge clk_i);
    penable_i = 1'b1;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
    @(negedge clk_i);
    penable_i = 1'b1;
    d = prdata_o;
    rd_cyc = cyc;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  // Register write that also applies the register-map rules to the model.
  task automatic op_write(input logic [31:0] a, input logic [31:0] d);
    int w, id;
    apb_write(a, d);
    w = int'(a[7:2]);
    if (w == 0) m_edge &= ~(d & m_mode);
    else if (w == 1) begin
      m_edge &= m_mode & d;
      m_mode = d;
    end else if (w == 3) begin
      m_tbase = d; m_tcyc = cyc;
    end else if (w >= 8 && w < 8 + NUM_TGT) m_en[w-8] = d;
    else if (w >= 16 && w < 16 + NUM_TGT) begin
      id = int'(d[4:0]);
      if (id < NUM_IRQ && m_mode[id]) m_edge[id] = 1'b0;
    end
  endtask

  task automatic drive_irqs(input logic [31:0] v);
    @(negedge clk_i);
    irqs_i = v[NUM_IRQ-1:0];
    m_edge |= v & ~m_lvl & m_mode;
    m_lvl = v;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; irqs_i = '0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_checks++;
    if (prdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", prdata_o); end
    n_checks++;
    if (irq_o !== '0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    apb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", d); end
    apb_read(32'h04, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mode: got %h expected 0", d); end
    apb_read(32'h40, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_claim0: got %h expected 0", d); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    do_reset();
    op_write(32'h04, 32'h1);
    op_write(32'h20, 32'h1);
    drive_irqs(32'h1);
    drive_irqs(32'h0);
    n_checks++;
    if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL edge_latency_1clk: got %b expected 0", irq_o[0]); end
    @(negedge clk_i);
    n_checks++;
    if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL edge_latency_2clk: got %b expected 1", irq_o[0]); end
    apb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL edge_pending: got %h expected 1", d); end
    apb_read(32'h40, d);
    n_checks++;
    if (d !== 32'h8000_0000) begin n_fail++; $display("FAIL edge_claim: got %h expected 80000000", d); end
    op_write(32'h40, 32'h0);
    apb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL edge_claim_clear: got %h expected 0", d); end
    n_checks++;
    if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL edge_irq_clear: got %b expected 0", irq_o[0]); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    do_reset();
    op_write(32'h04, 32'h0);
    op_write(32'h24, 32'h8);
    drive_irqs(32'h8);
    n_checks++;
    if (irq_o[1] !== 1'b0) begin n_fail++; $display("FAIL level_latency_0clk: got %b expected 0", irq_o[1]); end
    @(negedge clk_i);
    n_checks++;
    if (irq_o[1] !== 1'b1) begin n_fail++; $display("FAIL level_latency_1clk: got %b expected 1", irq_o[1]); end
    op_write(32'h00, 32'h8);
    apb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL level_w1c_ignored: got %h expected 8", d); end
    n_checks++;
    if (irq_o[1] !== 1'b1) begin n_fail++; $display("FAIL level_irq_held: got %b expected 1", irq_o[1]); end
    drive_irqs(32'h0);
    @(negedge clk_i);
    n_checks++;
    if (irq_o[1] !== 1'b0) begin n_fail++; $display("FAIL level_drop_irq: got %b expected 0", irq_o[1]); end
    apb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL level_drop_pending: got %h expected 0", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    do_reset();
    op_write(32'h04, 32'h24);
    op_write(32'h28, 32'h24);
    drive_irqs(32'h24);
    drive_irqs(32'h0);
    repeat (2) @(negedge clk_i);
    apb_read(32'h48, d);
    n_checks++;
    if (d !== 32'h8000_0002) begin n_fail++; $display("FAIL prio_first: got %h expected 80000002", d); end
    op_write(32'h48, 32'h2);
    apb_read(32'h48, d);
    n_checks++;
    if (d !== 32'h8000_0005) begin n_fail++; $display("FAIL prio_second: got %h expected 80000005", d); end
    op_write(32'h48, 32'h5);
    apb_read(32'h48, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL prio_empty: got %h expected 0", d); end
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    do_reset();
    op_write(32'h04, 32'h80);
    drive_irqs(32'h80);
    drive_irqs(32'h0);
    repeat (2) @(negedge clk_i);
    // W1C commit lands on the same edge as the detection of a new rising edge.
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h00; pwdata_i = 32'h80;
    irqs_i = NUM_IRQ'(32'h80);
    m_lvl = 32'h80;
    @(negedge clk_i);
    penable_i = 1'b1;
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    apb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h80) begin n_fail++; $display("FAIL set_beats_clear: got %h expected 80", d); end
    op_write(32'h00, 32'h80);
    apb_read(32'h00, d);
    n_checks++;
    if (d !== m_pending()) begin n_fail++; $display("FAIL plain_w1c: got %h expected %h", d, m_pending()); end
  endtask

  task automatic test_timer();
    logic [31:0] d, exp_t;
    do_reset();
    op_write(32'h0C, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk_i);
    apb_read(32'h0C, d);
    exp_t = m_tbase + 32'(rd_cyc - m_tcyc - 1);
    n_checks++;
    if (d !== exp_t) begin n_fail++; $display("FAIL timer_wrap: got %h expected %h", d, exp_t); end
    n_checks++;
    if (d >= 32'h10) begin n_fail++; $display("FAIL timer_wrapped_small: got %h expected below 10", d); end
    op_write(32'h0C, $urandom);
    repeat ($urandom_range(0, 20)) @(negedge clk_i);
    apb_read(32'h0C, d);
    exp_t = m_tbase + 32'(rd_cyc - m_tcyc - 1);
    n_checks++;
    if (d !== exp_t) begin n_fail++; $display("FAIL timer_random: got %h expected %h", d, exp_t); end
  endtask

  task automatic test_reserved();
    logic [31:0] d;
    do_reset();
    op_write(32'h04, 32'h1);
    op_write(32'h20, 32'h1);
    drive_irqs(32'h1);
    drive_irqs(32'h0);
    repeat (2) @(negedge clk_i);
    op_write(32'h10, 32'hFFFF_FFFF);
    op_write(32'h50, 32'h0);
    op_write(32'h30, 32'hFFFF_FFFF);
    apb_read(32'h10, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rsvd_0x10: got %h expected 0", d); end
    apb_read(32'h50, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rsvd_claim_tgt: got %h expected 0", d); end
    apb_read(32'h30, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rsvd_enable_tgt: got %h expected 0", d); end
    apb_read(32'h00, d);
    n_checks++;
    if (d !== m_pending()) begin n_fail++; $display("FAIL rsvd_pending_kept: got %h expected %h", d, m_pending()); end
    apb_read(32'h04, d);
    n_checks++;
    if (d !== m_mode) begin n_fail++; $display("FAIL rsvd_mode_kept: got %h expected %h", d, m_mode); end
    n_checks++;
    if (prdata_o !== 32'h0) begin n_fail++; $display("FAIL prdata_idle_zero: got %h expected 0", prdata_o); end
    n_checks++;
    if (irq_o !== m_irq()) begin n_fail++; $display("FAIL rsvd_irq: got %b expected %b", irq_o, m_irq()); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int t;
    logic [31:0] rsvd [4];
    rsvd[0] = 32'h10; rsvd[1] = 32'h14; rsvd[2] = 32'h30; rsvd[3] = 32'h50;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      t = $urandom_range(0, NUM_TGT - 1);
      case ($urandom_range(0, 5))
        0: begin
          drive_irqs($urandom & $urandom);
          repeat (3) @(negedge clk_i);
        end
        1: op_write(32'h04, $urandom);
        2: op_write(32'h20 + 32'(4 * t), $urandom | $urandom);
        3: op_write(32'h00, $urandom);
        4: begin
          d = m_claim(t);
          if (!d[31] || $urandom_range(0, 1) == 0) d = 32'($urandom_range(0, 31));
          op_write(32'h40 + 32'(4 * t), d);
        end
        default: op_write(rsvd[$urandom_range(0, 3)], $urandom);
      endcase
      apb_read(32'h00, d);
      n_checks++;
      if (d !== m_pending()) begin n_fail++; $display("FAIL rand_pending it=%0d: got %h expected %h", it, d, m_pending()); end
      n_checks++;
      if (irq_o !== m_irq()) begin n_fail++; $display("FAIL rand_irq it=%0d: got %b expected %b", it, irq_o, m_irq()); end
      t = $urandom_range(0, NUM_TGT - 1);
      apb_read(32'h40 + 32'(4 * t), d);
      e = m_claim(t);
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL rand_claim it=%0d t=%0d: got %h expected %h", it, t, d, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    op_write(32'h04, 32'hF);
    op_write(32'h20, 32'hF);
    drive_irqs(32'hF);
    drive_irqs(32'h0);
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h00;
    @(negedge clk_i);
    penable_i = 1'b1;
    n_checks++;
    if (prdata_o !== 32'hF) begin n_fail++; $display("FAIL pre_reset_prdata: got %h expected f", prdata_o); end
    n_checks++;
    if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq_o[0]); end
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if (prdata_o !== 32'h0) begin n_fail++; $display("FAIL async_reset_prdata: got %h expected 0", prdata_o); end
    n_checks++;
    if (irq_o !== '0) begin n_fail++; $display("FAIL async_reset_irq: got %b expected 0", irq_o); end
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    model_clear();
    apb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_pending: got %h expected 0", d); end
    apb_read(32'h20, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_enable: got %h expected 0", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_set_clear();
    test_timer();
    test_reserved();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
